// File: rtl/ps2_kb_pkg.sv
// Shared types for the simulated PS2 keyboard: Set 2 prefix bytes, encoder FSM
// states and the key-event record passed from the stimulus side.
package ps2_kb_pkg;

  localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
  localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREFIX,
    ST_BREAK,
    ST_CODE,
    ST_GAP
  } ps2_state_e;

  // release_key carries the key-release flag (release is a reserved word)
  typedef struct packed {
    logic [7:0] code;
    logic       extended;
    logic       release_key;
  } key_event_t;

  function automatic logic is_emit(input ps2_state_e s);
    return (s == ST_PREFIX) || (s == ST_BREAK) || (s == ST_CODE);
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous FIFO of key events; push is ignored when full, pop when empty.
module ps2_event_fifo
  import ps2_kb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  key_event_t               wr_data,
  input  logic                     pop,
  output key_event_t               rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  key_event_t        mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // storage needs no reset; only pointers define validity
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/ps2_scan_code_encoder.sv
// Expands queued key events into paced Set 2 byte strobes (E0 / F0 / code),
// at least GAP_CYCLES apart so the downstream serialiser buffer never overflows.
module ps2_scan_code_encoder
  import ps2_kb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ev_valid,
  output logic       ev_ready,
  input  logic [7:0] ev_code,
  input  logic       ev_extended,
  input  logic       ev_release,
  output logic       key_action,
  output logic [7:0] scan_code,
  output logic       busy
);

  localparam int         CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 2);

  key_event_t  wr_ev, head, ev_q, ev_d, cur_ev;
  logic        push, pop, full, empty;
  logic [CW-1:0] count;

  ps2_state_e  state_q, state_d, pend_q, pend_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  byte_d;

  assign wr_ev = '{code: ev_code, extended: ev_extended, release_key: ev_release};
  assign push  = ev_valid & ev_ready;
  assign pop   = (state_q == ST_IDLE) & ~empty;

  ps2_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data (wr_ev),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  assign ev_ready = ~full;
  assign busy     = (count != '0) | (state_q != ST_IDLE);

  // in IDLE the event being popped decides the first byte before it is latched
  assign cur_ev = (state_q == ST_IDLE) ? head : ev_q;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    ev_d    = ev_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          ev_d = head;
          if (head.code == 8'h00)   state_d = ST_IDLE;
          else if (head.extended)   state_d = ST_PREFIX;
          else if (head.release_key) state_d = ST_BREAK;
          else                      state_d = ST_CODE;
        end
      end
      ST_PREFIX: begin
        state_d = ST_GAP;
        cnt_d   = GAP_LOAD;
        pend_d  = ev_q.release_key ? ST_BREAK : ST_CODE;
      end
      ST_BREAK: begin
        state_d = ST_GAP;
        cnt_d   = GAP_LOAD;
        pend_d  = ST_CODE;
      end
      ST_CODE: begin
        state_d = ST_GAP;
        cnt_d   = GAP_LOAD;
        pend_d  = ST_IDLE;
      end
      ST_GAP: begin
        if (cnt_q == 8'd0) state_d = pend_q;
        else               cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    byte_d = scan_code;
    case (state_d)
      ST_PREFIX: byte_d = PS2_EXT_PREFIX;
      ST_BREAK:  byte_d = PS2_BREAK_PREFIX;
      ST_CODE:   byte_d = cur_ev.code;
      default:   byte_d = scan_code;
    endcase
  end

  // outputs registered from the next state so the strobe coincides with the emit state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pend_q     <= ST_IDLE;
      ev_q       <= '0;
      cnt_q      <= 8'd0;
      key_action <= 1'b0;
      scan_code  <= 8'h00;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      ev_q       <= ev_d;
      cnt_q      <= cnt_d;
      key_action <= is_emit(state_d);
      scan_code  <= byte_d;
    end
  end

endmodule
